// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, runtime baud divider, configurable frame format and an
// output FIFO whose entries carry parity/framing error tags alongside the payload.
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rx_i,
  input  logic                          rx_en_i,
  input  logic [DIV_W-1:0]              cfg_div_i,
  input  logic                          clr_i,
  output logic [DATA_BITS-1:0]          data_o,
  output logic                          perr_o,
  output logic                          ferr_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          overrun_o,
  output logic                          break_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = DATA_BITS + 2;

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StWaitHi
  } state_e;

  // Line synchroniser plus one history flop for falling-edge detection
  logic rx_meta_q, rxs_q, rxs_prev_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx_i;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  logic             start_edge;
  logic [DIV_W-1:0] div_eff;
  assign start_edge = rxs_prev_q & ~rxs_q;
  assign div_eff    = (cfg_div_i < DIV_W'(2)) ? DIV_W'(2) : cfg_div_i;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 stop_q, stop_d;

  logic push, push_ferr, push_perr, brk_set, last_stop;
  assign last_stop = (STOP_BITS == 1) || stop_q;

  // Receive FSM and bit-timing registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= DIV_W'(2);
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      ferr_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      ferr_q  <= ferr_d;
      stop_q  <= stop_d;
    end
  end

  // Next-state: each counting state samples rxs when cnt reaches zero, then reloads for one bit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    ferr_d    = ferr_q;
    stop_d    = stop_q;
    push      = 1'b0;
    push_ferr = 1'b0;
    push_perr = 1'b0;
    brk_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_en_i && start_edge) begin
          state_d = StStart;
          div_d   = div_eff;
          cnt_d   = div_eff >> 1;
        end
      end
      StStart: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (rxs_q) begin
          state_d = StIdle;
        end else begin
          state_d = StData;
          cnt_d   = div_q - DIV_W'(1);
          bit_d   = '0;
        end
      end
      StData: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = div_q - DIV_W'(1);
          if (bit_q == 4'(DATA_BITS - 1)) begin
            state_d = (PARITY_EN != 0) ? StParity : StStop;
            stop_d  = 1'b0;
            ferr_d  = 1'b0;
            par_d   = 1'b0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          par_d   = rxs_q;
          cnt_d   = div_q - DIV_W'(1);
          state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          cnt_d = div_q - DIV_W'(1);
          if (last_stop) begin
            push      = 1'b1;
            push_ferr = ferr_q | ~rxs_q;
            push_perr = (PARITY_EN != 0) && ((^shift_q ^ par_q) != (PARITY_ODD != 0));
            brk_set   = push_ferr && (shift_q == '0) && ((PARITY_EN == 0) || !par_q);
            // A low final stop bit means the line may be in a break; wait for it to rise
            state_d   = rxs_q ? StIdle : StWaitHi;
          end else begin
            stop_d = 1'b1;
            ferr_d = ferr_q | ~rxs_q;
          end
        end
      end
      StWaitHi: begin
        if (rxs_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output FIFO
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overrun_q, break_q;
  logic          full, pop, do_push, ovf;
  logic [EW-1:0] head;

  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign valid_o = (count_q != '0);
  assign pop     = valid_o & ready_i;
  // clr_i wins over a same-cycle push; a full FIFO still accepts when the head leaves this cycle
  assign do_push = push & (~full | pop) & ~clr_i;
  assign ovf     = push & full & ~pop & ~clr_i;

  // Pointers, occupancy and sticky status flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!do_push && pop) count_q <= count_q - (AW+1)'(1);
      overrun_q <= overrun_q | ovf;
      break_q   <= break_q | brk_set;
    end
  end

  // Storage array; no reset needed since reads are gated by valid_o
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_ferr, push_perr, shift_q};
  end

  assign head      = mem_q[rd_ptr_q];
  assign data_o    = valid_o ? head[DATA_BITS-1:0] : '0;
  assign perr_o    = valid_o & head[DATA_BITS];
  assign ferr_o    = valid_o & head[DATA_BITS+1];
  assign overrun_o = overrun_q;
  assign break_o   = break_q;
  assign level_o   = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance (directed corners plus randomized frames against a
// queue model) and an 8E1 instance (table of parity/framing vectors).
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8N1 instance signals
  logic        rx_a = 1'b1, en_a = 1'b1, clr_a = 1'b0, ready_a = 1'b0;
  logic [15:0] div_a = 16'd16;
  logic [7:0]  data_a;
  logic        perr_a, ferr_a, valid_a, ovr_a, brk_a;
  logic [4:0]  level_a;

  // 8E1 instance signals
  logic        rx_b = 1'b1, en_b = 1'b1, clr_b = 1'b0, ready_b = 1'b0;
  logic [15:0] div_b = 16'd16;
  logic [7:0]  data_b;
  logic        perr_b, ferr_b, valid_b, ovr_b, brk_b;
  logic [4:0]  level_b;

  uart_rx_fifo #(
    .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(16), .DIV_W(16)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_a), .rx_en_i(en_a), .cfg_div_i(div_a), .clr_i(clr_a),
    .data_o(data_a), .perr_o(perr_a), .ferr_o(ferr_a), .valid_o(valid_a), .ready_i(ready_a),
    .overrun_o(ovr_a), .break_o(brk_a), .level_o(level_a)
  );

  uart_rx_fifo #(
    .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .FIFO_DEPTH(16), .DIV_W(16)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx_b), .rx_en_i(en_b), .cfg_div_i(div_b), .clr_i(clr_b),
    .data_o(data_b), .perr_o(perr_b), .ferr_o(ferr_b), .valid_o(valid_b), .ready_i(ready_b),
    .overrun_o(ovr_b), .break_o(brk_b), .level_o(level_b)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] d;
    logic       pbit;
    logic       stopv;
    logic       e_perr;
    logic       e_ferr;
    logic       e_brk;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       ferr;
  } ent_t;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // One frame at 'div' clocks per bit, followed by a short idle gap
  task automatic send(input bit sel, input int div, input logic [7:0] d, input bit par_en,
                      input logic pbit, input logic stopv);
    set_rx(sel, 1'b0);
    tick(div);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      tick(div);
    end
    if (par_en) begin
      set_rx(sel, pbit);
      tick(div);
    end
    set_rx(sel, stopv);
    tick(div);
    set_rx(sel, 1'b1);
    tick(4);
  endtask

  task automatic pop_chk(input bit sel, input string nm, input logic [7:0] ed, input logic ep,
                         input logic ef);
    if (sel) begin
      chk({nm, ".valid"}, valid_b, 1);
      chk({nm, ".data"}, data_b, ed);
      chk({nm, ".perr"}, perr_b, ep);
      chk({nm, ".ferr"}, ferr_b, ef);
      ready_b = 1'b1;
      tick(1);
      ready_b = 1'b0;
    end else begin
      chk({nm, ".valid"}, valid_a, 1);
      chk({nm, ".data"}, data_a, ed);
      chk({nm, ".perr"}, perr_a, ep);
      chk({nm, ".ferr"}, ferr_a, ef);
      ready_a = 1'b1;
      tick(1);
      ready_a = 1'b0;
    end
  endtask

  task automatic clr_pulse(input bit sel);
    if (sel) clr_b = 1'b1;
    else     clr_a = 1'b1;
    tick(1);
    clr_b = 1'b0;
    clr_a = 1'b0;
    tick(1);
  endtask

  initial begin
    vec_t tv[9];
    ent_t q[$];
    ent_t e;
    logic [7:0] dat;
    logic stp;
    bit eovr, ebrk;
    int d, k;

    // Parity/framing vectors for the even-parity instance, expectations derived by hand
    tv[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[1] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[3] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[4] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[6] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[7] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[8] = '{8'h7E, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    tick(3);
    chk("rst.valid", valid_a, 0);
    chk("rst.level", level_a, 0);
    chk("rst.data", data_a, 0);
    chk("rst.perr", perr_a, 0);
    chk("rst.ferr", ferr_a, 0);
    chk("rst.overrun", ovr_a, 0);
    chk("rst.break", brk_a, 0);
    chk("rst.valid_b", valid_b, 0);
    rst_n = 1'b1;
    tick(3);

    // Single 8N1 frame
    send(0, 16, 8'h41, 0, 1'b0, 1'b1);
    chk("t1.level", level_a, 1);
    pop_chk(0, "t1", 8'h41, 1'b0, 1'b0);
    chk("t1.level_after_pop", level_a, 0);

    // Short low glitch rejected in START; receiver still works afterwards
    rx_a = 1'b0;
    tick(4);
    rx_a = 1'b1;
    tick(40);
    chk("glitch.level", level_a, 0);
    chk("glitch.valid", valid_a, 0);
    send(0, 16, 8'h5A, 0, 1'b0, 1'b1);
    pop_chk(0, "glitch.next", 8'h5A, 1'b0, 1'b0);

    // Disabled receiver ignores a frame
    en_a = 1'b0;
    send(0, 16, 8'h33, 0, 1'b0, 1'b1);
    chk("rxen.level", level_a, 0);
    en_a = 1'b1;

    // clr and divider change mid-frame do not disturb the frame in flight
    fork
      send(0, 16, 8'h66, 0, 1'b0, 1'b1);
      begin
        tick(64);
        div_a = 16'd3;
        clr_pulse(0);
      end
    join
    div_a = 16'd16;
    chk("midclr.level", level_a, 1);
    pop_chk(0, "midclr", 8'h66, 1'b0, 1'b0);

    // Overflow: 17 frames with no consumer
    for (int i = 0; i <= 16; i++) send(0, 16, 8'(i), 0, 1'b0, 1'b1);
    chk("ovf.level", level_a, 16);
    chk("ovf.overrun", ovr_a, 1);
    tick(5);
    chk("ovf.head_stable", data_a, 0);
    for (int i = 0; i < 16; i++) pop_chk(0, $sformatf("ovf.pop%0d", i), 8'(i), 1'b0, 1'b0);
    chk("ovf.level_empty", level_a, 0);
    chk("ovf.valid_empty", valid_a, 0);
    chk("ovf.overrun_sticky", ovr_a, 1);
    clr_pulse(0);
    chk("ovf.overrun_clr", ovr_a, 0);

    // Break: line low for three frame times
    rx_a = 1'b0;
    tick(30 * 16);
    chk("brk.level", level_a, 1);
    chk("brk.flag", brk_a, 1);
    rx_a = 1'b1;
    tick(40);
    chk("brk.level_after_high", level_a, 1);
    pop_chk(0, "brk", 8'h00, 1'b0, 1'b1);
    chk("brk.level_empty", level_a, 0);
    clr_pulse(0);
    chk("brk.clr", brk_a, 0);

    // Reset during DATA with an entry already queued
    send(0, 16, 8'h99, 0, 1'b0, 1'b1);
    rx_a = 1'b0;
    tick(16);
    rx_a = 1'b1;
    tick(16);
    rx_a = 1'b0;
    tick(8);
    rst_n = 1'b0;
    tick(1);
    chk("mrst.valid", valid_a, 0);
    chk("mrst.level", level_a, 0);
    chk("mrst.data", data_a, 0);
    rx_a = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    send(0, 16, 8'h3C, 0, 1'b0, 1'b1);
    chk("mrst.level_after", level_a, 1);
    pop_chk(0, "mrst", 8'h3C, 1'b0, 1'b0);
    chk("mrst.level_end", level_a, 0);

    // Randomized rounds against a queue model
    for (int r = 0; r < 4; r++) begin
      d = $urandom_range(10, 24);
      div_a = 16'(d);
      k = $urandom_range(1, 20);
      q.delete();
      eovr = 1'b0;
      ebrk = 1'b0;
      for (int j = 0; j < k; j++) begin
        dat = 8'($urandom);
        stp = ($urandom_range(0, 3) != 0);
        if (r == 1 && j == k - 1) begin
          dat = 8'h00;
          stp = 1'b0;
        end
        send(0, d, dat, 0, 1'b0, stp);
        if (!stp && dat == 8'h00) ebrk = 1'b1;
        if (q.size() < 16) q.push_back('{dat, !stp});
        else eovr = 1'b1;
      end
      chk($sformatf("rnd%0d.level", r), level_a, q.size());
      chk($sformatf("rnd%0d.overrun", r), ovr_a, eovr);
      chk($sformatf("rnd%0d.break", r), brk_a, ebrk);
      while (q.size() > 0) begin
        e = q.pop_front();
        pop_chk(0, $sformatf("rnd%0d.pop", r), e.d, 1'b0, e.ferr);
      end
      chk($sformatf("rnd%0d.drained", r), valid_a, 0);
      clr_pulse(0);
      chk($sformatf("rnd%0d.ovr_clr", r), ovr_a, 0);
    end

    // Table vectors on the even-parity instance
    for (int i = 0; i < 9; i++) begin
      clr_pulse(1);
      send(1, 16, tv[i].d, 1, tv[i].pbit, tv[i].stopv);
      chk($sformatf("tv%0d.level", i), level_b, 1);
      chk($sformatf("tv%0d.break", i), brk_b, tv[i].e_brk);
      pop_chk(1, $sformatf("tv%0d", i), tv[i].d, tv[i].e_perr, tv[i].e_ferr);
      chk($sformatf("tv%0d.level_after", i), level_b, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
